term_writer: RTL and testbench

Character-stream front end for the text-mode VGA stage. It accepts bytes over a valid/ready handshake, interprets a small set of control codes, and tracks a cursor on the 80x25 cell grid. It emits single-cycle writes on the `wr_en`/`wr_addr`/`wr_data` port that feeds the text stage's index RAM. There is no scrolling: whenever the cursor enters a row, that row is blanked first.

---
 rtl/term_writer.sv | 149 ++++++++++++++
 tb/tb_term_writer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_writer.sv
// term_writer: byte stream to text-cell writer for the 80x25 VGA text stage.
// Takes bytes over valid/ready, handles CR/LF/BS/FF, and tracks a cursor.
// Cell writes go out one per cycle on wr_en/wr_addr/wr_data. There is no
// scrolling, so a row is blanked whenever the cursor enters it.
// Optional build macro TERM_WRITER_CLEAR_ON_RESET_EN: when it is defined, the
// block blanks the whole screen after reset is released.
module term_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 25,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam int            CW       = $clog2(COLS*ROWS+1);
  localparam logic [CW-1:0] CNT_ROW  = CW'(COLS);
  localparam logic [CW-1:0] CNT_ALL  = CW'(COLS*ROWS);
  localparam logic [6:0]    LAST_COL = 7'(COLS-1);
  localparam logic [4:0]    LAST_ROW = 5'(ROWS-1);

`ifdef TERM_WRITER_CLEAR_ON_RESET_EN
  localparam logic [0:0]    S_RESET   = S_CLEAR;
  localparam logic [CW-1:0] CNT_RESET = CNT_ALL;
`else
  localparam logic [0:0]    S_RESET   = S_IDLE;
  localparam logic [CW-1:0] CNT_RESET = '0;
`endif

  logic [0:0]    state;
  logic [10:0]   clr_addr;
  logic [CW-1:0] clr_left;

  // Command decode results for the byte currently offered.
  logic [6:0]    nxt_col;
  logic [4:0]    nxt_row;
  logic          do_wr;
  logic [10:0]   w_addr;
  logic [7:0]    w_data;
  logic          clr_go;
  logic [10:0]   clr_base;
  logic [CW-1:0] clr_cnt;
  logic          row_adv;
  logic [10:0]   cell_addr;

  assign in_ready  = (state == S_IDLE);
  assign cell_addr = 11'(cur_row) * 11'(COLS) + 11'(cur_col);

  // Decode the offered byte into the post-command cursor, an optional cell
  // write and an optional clear run.
  always_comb begin
    nxt_col  = cur_col;
    nxt_row  = cur_row;
    do_wr    = 1'b0;
    w_addr   = cell_addr;
    w_data   = in_data;
    clr_go   = 1'b0;
    clr_base = '0;
    clr_cnt  = CNT_ROW;
    row_adv  = 1'b0;
    if (in_data >= 8'h20 && in_data != 8'h7F) begin
      do_wr = 1'b1;
      if (cur_col == LAST_COL) begin
        nxt_col = '0;
        row_adv = 1'b1;
      end else begin
        nxt_col = cur_col + 7'd1;
      end
    end else begin
      case (in_data)
        8'h0D: nxt_col = '0;
        8'h0A: row_adv = 1'b1;
        8'h08: begin
          if (cur_col != '0) begin
            nxt_col = cur_col - 7'd1;
            do_wr   = 1'b1;
            w_addr  = cell_addr - 11'd1;
            w_data  = BLANK;
          end
        end
        8'h0C: begin
          nxt_col = '0;
          nxt_row = '0;
          clr_go  = 1'b1;
          clr_cnt = CNT_ALL;
        end
        default: ;
      endcase
    end
    // Entering a new row always blanks it; the last row wraps to the top.
    if (row_adv) begin
      nxt_row  = (cur_row == LAST_ROW) ? 5'd0 : cur_row + 5'd1;
      clr_go   = 1'b1;
      clr_base = 11'(nxt_row) * 11'(COLS);
      clr_cnt  = CNT_ROW;
    end
  end

  // Cursor, clear sequencer and registered write port.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      clr_addr <= '0;
      clr_left <= CNT_RESET;
      cur_col  <= '0;
      cur_row  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state == S_CLEAR) begin
        wr_en    <= 1'b1;
        wr_addr  <= clr_addr;
        wr_data  <= BLANK;
        clr_addr <= clr_addr + 11'd1;
        clr_left <= clr_left - CW'(1);
        if (clr_left == CW'(1)) state <= S_IDLE;
      end else if (in_valid) begin
        cur_col <= nxt_col;
        cur_row <= nxt_row;
        if (do_wr) begin
          wr_en   <= 1'b1;
          wr_addr <= w_addr;
          wr_data <= w_data;
        end
        // The clear run starts on the next edge, directly behind any
        // character write issued on this one.
        if (clr_go) begin
          state    <= S_CLEAR;
          clr_addr <= clr_base;
          clr_left <= clr_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// tb_term_writer: directed table, hand-written corner sequences and random
// bytes, all compared against a queue-based model of the cell writes.
module tb_term_writer;

  logic        clk100;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  term_writer dut (
    .clk100  (clk100),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cur_col (cur_col),
    .cur_row (cur_row)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

`ifdef TERM_WRITER_CLEAR_ON_RESET_EN
  localparam int RST_READY = 0;
`else
  localparam int RST_READY = 1;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int addr; int data; } wr_t;
  wr_t sched[$];       // clear writes still to be issued, oldest first
  wr_t exp_w;          // write expected to be visible after the last edge
  bit  exp_wv   = 0;
  int  m_col    = 0;
  int  m_row    = 0;
  bit  model_on = 0;
  bit  acc_flag = 0;   // byte accepted on the last edge
  int  cyc      = 0;
  int  acc_cyc  = 0;

  task automatic blank_row(input int r);
    for (int c = 0; c < 80; c++) sched.push_back('{r*80 + c, 32'h20});
  endtask

  task automatic blank_all();
    for (int a = 0; a < 2000; a++) sched.push_back('{a, 32'h20});
  endtask

  task automatic model_byte(input int b);
    if (b >= 8'h20 && b != 8'h7F) begin
      exp_w = '{m_row*80 + m_col, b}; exp_wv = 1;
      m_col++;
      if (m_col == 80) begin m_col = 0; m_row = (m_row + 1) % 25; blank_row(m_row); end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) begin m_row = (m_row + 1) % 25; blank_row(m_row); end
    else if (b == 8'h08) begin
      if (m_col > 0) begin m_col--; exp_w = '{m_row*80 + m_col, 32'h20}; exp_wv = 1; end
    end else if (b == 8'h0C) begin m_col = 0; m_row = 0; blank_all(); end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; exp_wv = 0; acc_flag = 0;
    sched.delete();
`ifdef TERM_WRITER_CLEAR_ON_RESET_EN
    blank_all();
`endif
  endtask

  // Advance the model one edge: pending clear writes take priority over input.
  always @(posedge clk100) begin
    cyc++;
    acc_flag = 0;
    if (model_on) begin
      exp_wv = 0;
      if (sched.size() != 0) begin
        exp_w = sched.pop_front(); exp_wv = 1;
      end else if (in_valid) begin
        acc_flag = 1; acc_cyc = cyc;
        model_byte(int'(in_data));
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk100) begin
    if (model_on) begin
      chk("wr_en", int'(wr_en), int'(exp_wv));
      if (exp_wv && wr_en) begin
        chk("wr_addr", int'(wr_addr), exp_w.addr);
        chk("wr_data", int'(wr_data), exp_w.data);
      end
      chk("in_ready", int'(in_ready), int'(sched.size() == 0));
      chk("cur_col", int'(cur_col), m_col);
      chk("cur_row", int'(cur_row), m_row);
    end
  end

  // ---------------- driver ----------------
  // Offer a byte until the model sees it taken; returns at the negedge after
  // the accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    do begin @(negedge clk100); n++; end while (!acc_flag && n < 3000);
    in_valid = 1'b0;
    if (!acc_flag) chk("send_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] b;
    int wr; int addr; int data; int col; int row;
  } vec_t;
  vec_t tbl[13];

  int c0, low;

  initial begin
    tbl[0]  = '{8'h41, 1, 0,  8'h41, 1, 0};
    tbl[1]  = '{8'h42, 1, 1,  8'h42, 2, 0};
    tbl[2]  = '{8'h0D, 0, 0,  0,     0, 0};
    tbl[3]  = '{8'h08, 0, 0,  0,     0, 0};
    tbl[4]  = '{8'h78, 1, 0,  8'h78, 1, 0};
    tbl[5]  = '{8'h7F, 0, 0,  0,     1, 0};
    tbl[6]  = '{8'h80, 1, 1,  8'h80, 2, 0};
    tbl[7]  = '{8'h08, 1, 1,  8'h20, 1, 0};
    tbl[8]  = '{8'h00, 0, 0,  0,     1, 0};
    tbl[9]  = '{8'h0A, 0, 0,  0,     1, 1};
    tbl[10] = '{8'h43, 1, 81, 8'h43, 2, 1};
    tbl[11] = '{8'h0C, 0, 0,  0,     0, 0};
    tbl[12] = '{8'h44, 1, 0,  8'h44, 1, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk100);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_col", int'(cur_col), 0);
    chk("rst_row", int'(cur_row), 0);
    chk("rst_ready", int'(in_ready), RST_READY);
    #2 rst_n = 1'b1; model_reset(); model_on = 1;

    // Directed table from a home cursor.
    foreach (tbl[i]) begin
      send(tbl[i].b);
      chk("tbl_wr_en", int'(wr_en), tbl[i].wr);
      if (tbl[i].wr != 0) begin
        chk("tbl_addr", int'(wr_addr), tbl[i].addr);
        chk("tbl_data", int'(wr_data), tbl[i].data);
      end
      chk("tbl_col", int'(cur_col), tbl[i].col);
      chk("tbl_row", int'(cur_row), tbl[i].row);
    end

    // Full row of printables: wrap plus 80-cycle row clear.
    send(8'h0C);
    for (int i = 0; i < 80; i++) send(8'h61 + 8'(i % 26));
    chk("row80_addr", int'(wr_addr), 79);
    chk("row80_wr_en", int'(wr_en), 1);
    low = 0;
    while (!in_ready && low < 200) begin low++; @(negedge clk100); end
    chk("row80_busy_cycles", low, 80);
    chk("row80_col", int'(cur_col), 0);
    chk("row80_row", int'(cur_row), 1);

    // LF on the last row wraps to row 0, keeps the column.
    for (int i = 0; i < 23; i++) send(8'h0A);
    chk("lf_row24", int'(cur_row), 24);
    send(8'h0D);
    for (int i = 0; i < 5; i++) send(8'h2E);
    send(8'h0A);
    chk("lfwrap_row", int'(cur_row), 0);
    chk("lfwrap_col", int'(cur_col), 5);
    send(8'h0D);
    send(8'h42);
    chk("cr_b_addr", int'(wr_addr), 0);
    chk("cr_b_data", int'(wr_data), 8'h42);

    // Backspace at column 0 and column 3.
    send(8'h0D);
    send(8'h08);
    chk("bs0_wr_en", int'(wr_en), 0);
    chk("bs0_col", int'(cur_col), 0);
    send(8'h78); send(8'h79); send(8'h7A);
    send(8'h08);
    chk("bs3_addr", int'(wr_addr), 2);
    chk("bs3_data", int'(wr_data), 8'h20);
    chk("bs3_col", int'(cur_col), 2);

    // FF with the next byte waiting behind it.
    send(8'h0C);
    c0 = acc_cyc;
    send(8'h5A);
    chk("ff_hold_latency", acc_cyc - c0, 2001);
    chk("ff_next_addr", int'(wr_addr), 0);
    chk("ff_next_data", int'(wr_data), 8'h5A);

    // Random bytes against the model, with occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if      (r < 70) b = 8'($urandom_range(8'h20, 8'hFF));
      else if (r < 77) b = 8'h0D;
      else if (r < 82) b = 8'h0A;
      else if (r < 92) b = 8'h08;
      else if (r < 93) b = 8'h0C;
      else if (r < 96) b = 8'h7F;
      else             b = 8'($urandom_range(0, 8'h1F));
      send(b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk100);
    end

    // Reset in the middle of a full clear.
    send(8'h0C);
    repeat (40) @(negedge clk100);
    chk("midclr_addr", int'(wr_addr), 39);
    chk("midclr_wr_en", int'(wr_en), 1);
    #2 rst_n = 1'b0; model_on = 0;
    #1;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_col", int'(cur_col), 0);
    chk("midrst_row", int'(cur_row), 0);
    chk("midrst_addr", int'(wr_addr), 0);
    chk("midrst_ready", int'(in_ready), RST_READY);
    @(negedge clk100);
    #2 rst_n = 1'b1; model_reset(); model_on = 1;
    send(8'h51);
    chk("postrst_addr", int'(wr_addr), 0);
    chk("postrst_data", int'(wr_data), 8'h51);
    chk("postrst_col", int'(cur_col), 1);

    repeat (3) @(negedge clk100);
    model_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
